icache: RTL and testbench

- Direct-mapped, read-only instruction cache; the responder side of the datapath's instruction-fetch interface (imemREN/imemaddr -> ihit/imemload).
- Sits between the pipelined datapath and the memory controller.
- Issues single-word fills (iREN/iaddr, waits on iwait) on a miss.
- Datapath advances PC only on ihit, so the cache must never return ihit with stale or wrong data.

---
 rtl/icache.sv | 123 ++++++++++++
 tb/tb_icache.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with single-word fills
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    logic [TAG_W-1:0] ltag;
    logic [IDX_W-1:0] lidx;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             miss;
    logic             fill;
    logic             unused_byte_bits;

    assign req_tag          = imemaddr[31:IDX_W+2];
    assign req_idx          = imemaddr[IDX_W+1:2];
    assign unused_byte_bits = ^imemaddr[1:0];

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        miss       = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (valid[req_idx] && (tags[req_idx] == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = data[req_idx];
                    end else begin
                        miss       = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                // The fill targets the latched frame, whatever the datapath now asks for.
                iREN  = 1'b1;
                iaddr = {ltag, lidx, 2'b00};
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            ltag  <= '0;
            lidx  <= '0;
            valid <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (miss) begin
                ltag <= req_tag;
                lidx <= req_idx;
            end
            if (fill) begin
                valid[lidx] <= 1'b1;
                tags[lidx]  <= ltag;
                data[lidx]  <= iload;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'h1;
            end
            if (miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed bench for icache with a word-address cache model
// Model tracks which full word address each frame holds and any outstanding fill.
module tb_icache;

    localparam int SETS = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.SETS(SETS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [SETS];
    logic [29:0] m_waddr [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_pend;
    logic [29:0] m_pwaddr;
    int unsigned m_hits;
    int unsigned m_misses;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2008_0001;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_waddr[i] = '0;
            m_data[i]  = '0;
        end
        m_pend   = 1'b0;
        m_pwaddr = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step();
        logic [29:0] w;
        int          idx;
        bit          e_hit;
        if (!nRST) begin
            check("rst_ihit", {31'b0, ihit}, 32'h0);
            check("rst_imemload", imemload, 32'h0);
            check("rst_iren", {31'b0, iREN}, 32'h0);
            check("rst_iaddr", iaddr, 32'h0);
            model_clear();
        end else begin
            w     = imemaddr[31:2];
            idx   = int'(w) % SETS;
            e_hit = !m_pend && imemREN && m_valid[idx] && (m_waddr[idx] == w);
            check("m_ihit", {31'b0, ihit}, {31'b0, e_hit});
            check("m_imemload", imemload, e_hit ? m_data[idx] : 32'h0);
            check("m_iren", {31'b0, iREN}, {31'b0, m_pend});
            if (m_pend) check("m_iaddr", iaddr, {m_pwaddr, 2'b00});
`ifdef ICACHE_STATS_EN
            check("m_hit_count", hit_count, m_hits);
            check("m_miss_count", miss_count, m_misses);
`endif
            if (m_pend) begin
                if (!iwait) begin
                    idx          = int'(m_pwaddr) % SETS;
                    m_valid[idx] = 1'b1;
                    m_waddr[idx] = m_pwaddr;
                    m_data[idx]  = mem_fn({m_pwaddr, 2'b00});
                    m_pend       = 1'b0;
                end
            end else if (imemREN) begin
                if (e_hit) begin
                    m_hits++;
                end else begin
                    m_pend   = 1'b1;
                    m_pwaddr = w;
                    m_misses++;
                end
            end
        end
    endtask

    task automatic go(input logic rn, input logic ren, input logic [31:0] a, input logic wt);
        @(posedge CLK);
        #1;
        nRST     = rn;
        imemREN  = ren;
        imemaddr = a;
        iwait    = wt;
        #1;
        iload = iREN ? mem_fn(iaddr) : 32'hDEAD_BEEF;
        @(negedge CLK);
        model_step();
    endtask

    task automatic g(input logic ren, input logic [31:0] a, input logic wt);
        go(1'b1, ren, a, wt);
    endtask

    int fills;

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        iload    = 32'h0;
        model_clear();
        go(1'b0, 1'b0, 32'h0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 1'b0);

        // first miss, one-cycle fill, hit on the following cycle
        g(1'b1, 32'h40, 1'b0);
        check("t1_miss_ihit", {31'b0, ihit}, 32'h0);
        g(1'b1, 32'h40, 1'b0);
        check("t1_fetch_iren", {31'b0, iREN}, 32'h1);
        check("t1_fetch_iaddr", iaddr, 32'h0000_0040);
        g(1'b1, 32'h40, 1'b0);
        check("t1_hit", {31'b0, ihit}, 32'h1);
        check("t1_load", imemload, 32'h2008_0001);

        g(1'b1, 32'h40, 1'b0);
        check("t2_hit", {31'b0, ihit}, 32'h1);
        check("t2_iren", {31'b0, iREN}, 32'h0);
        g(1'b0, 32'h40, 1'b0);
        check("t2_noreq_ihit", {31'b0, ihit}, 32'h0);
`ifdef ICACHE_STATS_EN
        check("t2_hit_count", hit_count, 32'd2);
        check("t2_miss_count", miss_count, 32'd1);
`endif

        // miss with three wait cycles
        g(1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 4; i++) begin
            g(1'b1, 32'h80, (i < 3) ? 1'b1 : 1'b0);
            check("t3_iren", {31'b0, iREN}, 32'h1);
            check("t3_iaddr", iaddr, 32'h0000_0080);
            check("t3_ihit", {31'b0, ihit}, 32'h0);
        end
        g(1'b1, 32'h80, 1'b0);
        check("t3_hit", {31'b0, ihit}, 32'h1);
        check("t3_load", imemload, 32'h0080_FF7F);

        // conflict pair on frame 1
        fills = 0;
        g(1'b1, 32'h04, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h04, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h44, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h44, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h04, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h04, 1'b0); if (iREN) fills++;
        g(1'b1, 32'h04, 1'b0); if (iREN) fills++;
        check("t4_fills", fills, 32'd3);
        check("t4_hit", {31'b0, ihit}, 32'h1);
        check("t4_load", imemload, 32'h0004_FFFB);

        // request changes during the fill
        g(1'b1, 32'h100, 1'b0);
        g(1'b1, 32'h200, 1'b1);
        check("t5_iaddr_held", iaddr, 32'h0000_0100);
        g(1'b1, 32'h200, 1'b0);
        check("t5_iaddr_fill", iaddr, 32'h0000_0100);
        g(1'b1, 32'h100, 1'b0);
        check("t5_hit_100", {31'b0, ihit}, 32'h1);
        check("t5_load_100", imemload, 32'h0100_FEFF);
        g(1'b1, 32'h200, 1'b0);
        check("t5_miss_200", {31'b0, ihit}, 32'h0);
        g(1'b1, 32'h200, 1'b0);
        check("t5_iaddr_200", iaddr, 32'h0000_0200);
        g(1'b1, 32'h200, 1'b0);
        check("t5_load_200", imemload, 32'h0200_FDFF);

        // reset in the middle of a fill
        g(1'b1, 32'h40, 1'b0);
        g(1'b1, 32'h40, 1'b0);
        g(1'b1, 32'h40, 1'b0);
        check("t6_cached_40", {31'b0, ihit}, 32'h1);
        g(1'b1, 32'hC4, 1'b0);
        g(1'b1, 32'hC4, 1'b1);
        check("t6_fetch_iren", {31'b0, iREN}, 32'h1);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("t6_iren_drop", {31'b0, iREN}, 32'h0);
        go(1'b0, 1'b0, 32'h0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 1'b0);
        g(1'b1, 32'h40, 1'b0);
        check("t6_miss_40", {31'b0, ihit}, 32'h0);
        g(1'b1, 32'h40, 1'b0);
        check("t6_refetch_iren", {31'b0, iREN}, 32'h1);
        check("t6_refetch_iaddr", iaddr, 32'h0000_0040);
        g(1'b1, 32'h40, 1'b0);
        check("t6_rehit", imemload, 32'h2008_0001);
        g(1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
